// File: rtl/mem_loader_if.sv
// Byte-stream handshake plus memory-write strobe bundle between a host byte
// link (master) and mem_loader (slave).
interface mem_loader_if #(
    parameter int WIDTH = 8,
    parameter int ADDRW = 9
);
    logic             start;
    logic [ADDRW-1:0] base_addr;
    logic [ADDRW:0]   len;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             wr_en;
    logic [ADDRW-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;

    modport master (
        output start, base_addr, len, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, base_addr, len, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/mem_loader.sv
// Packs a little-endian byte stream into WIDTH-bit words and writes them to
// consecutive (wrapping) addresses from a latched base; pulses done at the end.
module mem_loader #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 512,
    localparam int ADDRW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BPW   = (WIDTH + 7) / 8
) (
    input logic         clk,
    input logic         rst,
    mem_loader_if.slave bus
);
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW:0]   MAX_LEN   = (ADDRW + 1)'(DEPTH);
    localparam logic [BCW-1:0]   LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic {
        IDLE,
        LOAD
    } state_e;

    state_e           state_q,    state_d;
    logic [ADDRW-1:0] addr_q,     addr_d;
    logic [ADDRW:0]   len_q,      len_d;
    logic [ADDRW:0]   word_cnt_q, word_cnt_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BPW*8-1:0] asm_q,      asm_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q,     busy_d;
    logic             wr_en_q,    wr_en_d;
    logic             done_q,     done_d;
    logic [ADDRW-1:0] wr_addr_q,  wr_addr_d;
    logic [WIDTH-1:0] wr_data_q,  wr_data_d;

    always_comb begin
        // NOTE: every _d takes its hold value first so no branch can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d     = bus.base_addr;
                    len_d      = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    if (bus.len != '0) state_d = LOAD;
                    else               done_d  = 1'b1;
                end
            end
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    asm_d[8*int'(byte_cnt_q) +: 8] = bus.in_data;
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Truncating cast drops the unused top bits of the last byte.
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = WIDTH'(asm_d);
                        addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDRW'(1);
                        word_cnt_d = word_cnt_q + (ADDRW + 1)'(1);
                        byte_cnt_d = '0;
                        if (word_cnt_d == len_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.done     = done_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
endmodule
